wishbone_gpio_bank: RTL

- Multi-channel Wishbone bus slave for general-purpose I/O.
- Successor to the single output register. Provides CHANNELS output registers with assign/set/clear/invert write modes, plus synchronised inputs, rising-edge event flags and a level interrupt.
- Sits on the peripheral Wishbone bus and drives board-level pins and the interrupt controller.
- Acknowledge and read data are registered; every access takes one wait state.

---
 rtl/wishbone_gpio_bank_if.sv | 31 +++
 rtl/wishbone_gpio_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wishbone_gpio_bank_if.sv
// Wishbone classic slave bundle shared by the GPIO bank and its bus masters.
// The clock travels with the bus so every agent samples on the same edge.
interface wishboneSlave #(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int ADR_WIDTH    = 32
) (
    input logic clk_i
);
    logic                    cyc_i;
    logic                    stb_i;
    logic                    we_i;
    logic [ADR_WIDTH-1:0]    adr_i;
    logic [SELECT_WIDTH-1:0] sel_i;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    ack_o;
    logic                    err_o;
    logic                    rty_o;
    logic                    tgd_o;

    modport slave (
        input  clk_i, cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o, rty_o, tgd_o
    );

    modport master (
        input  clk_i, dat_o, ack_o, err_o, rty_o, tgd_o,
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i
    );
endinterface

// File: rtl/wishbone_gpio_bank.sv
// Multi-channel Wishbone GPIO: output registers with set/clear/invert modes,
// synchronised inputs, rising-edge event flags and a level interrupt.
module wishbone_gpio_bank #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = 4,
    parameter int                    CHANNELS     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PAT    = {DATA_WIDTH{1'b0}},
    parameter int                    SYNC_STAGES  = 2,
    parameter logic                  TGD          = 1'b0
) (
    input  logic                           reset,
    wishboneSlave.slave                    bus,
    input  logic [CHANNELS*DATA_WIDTH-1:0] gpio_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] gpio_out,
    output logic                           irq
);
    localparam int SB = $clog2(SELECT_WIDTH);
    localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int GW = DATA_WIDTH / SELECT_WIDTH;
    localparam int NW = CHANNELS * DATA_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] sel_mask(input logic [SELECT_WIDTH-1:0] sel);
        logic [DATA_WIDTH-1:0] m;
        m = {DATA_WIDTH{1'b0}};
        for (int g = 0; g < SELECT_WIDTH; g++) begin
            m[g*GW +: GW] = {GW{sel[g]}};
        end
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] apply_mode(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] wr_v,
        input logic [DATA_WIDTH-1:0] mask,
        input logic [1:0]            mode
    );
        logic [DATA_WIDTH-1:0] res;
        case (mode)
            2'd0:    res = wr_v;
            2'd1:    res = old_v | wr_v;
            2'd2:    res = old_v & ~wr_v;
            2'd3:    res = old_v ^ wr_v;
            default: res = old_v;
        endcase
        return (old_v & ~mask) | (res & mask);
    endfunction

    state_t                          state_q, state_d;
    logic                            ack_q, ack_d;
    logic                            err_q, err_d;
    logic                            irq_q;
    logic [DATA_WIDTH-1:0]           dat_q, dat_d;
    logic [NW-1:0]                   out_q, out_d;
    logic [NW-1:0]                   en_q, en_d;
    logic [NW-1:0]                   flag_q, flag_d;
    logic [NW-1:0]                   prev_q;
    logic [SYNC_STAGES-1:0][NW-1:0]  sync_q;

    logic [1:0]            mode_s;
    logic [1:0]            region_s;
    logic [CB-1:0]         chan_s;
    logic [CB-1:0]         chan_idx_s;
    logic                  chan_ok_s;
    logic                  bad_s;
    logic [DATA_WIDTH-1:0] mask_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [NW-1:0]         w1c_s;
    logic [NW-1:0]         rise_s;
    logic                  unused_s;

    assign mode_s     = bus.adr_i[SB+1:SB];
    assign region_s   = bus.adr_i[SB+3:SB+2];
    assign chan_s     = bus.adr_i[SB+4+CB-1:SB+4];
    assign chan_ok_s  = (int'(chan_s) < CHANNELS);
    assign chan_idx_s = chan_ok_s ? chan_s : {CB{1'b0}};
    assign bad_s      = !chan_ok_s || (bus.we_i && (region_s == 2'd1));
    assign mask_s     = sel_mask(bus.sel_i);
    assign rise_s     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign unused_s   = ^bus.adr_i;

    // Read mux: value of the addressed register before any write on this edge.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        case (region_s)
            2'd0:    rd_data_s = out_q[chan_idx_s*DATA_WIDTH +: DATA_WIDTH];
            2'd1:    rd_data_s = sync_q[SYNC_STAGES-1][chan_idx_s*DATA_WIDTH +: DATA_WIDTH];
            2'd2:    rd_data_s = flag_q[chan_idx_s*DATA_WIDTH +: DATA_WIDTH];
            2'd3:    rd_data_s = en_q[chan_idx_s*DATA_WIDTH +: DATA_WIDTH];
            default: rd_data_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Bus FSM next state, response and register write decode.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        out_d   = out_q;
        en_d    = en_q;
        w1c_s   = {NW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (bus.cyc_i && bus.stb_i) begin
                    state_d = ST_RESP;
                    if (bad_s) begin
                        err_d = 1'b1;
                        dat_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        ack_d = 1'b1;
                        dat_d = rd_data_s;
                        if (bus.we_i) begin
                            case (region_s)
                                2'd0: out_d[chan_idx_s*DATA_WIDTH +: DATA_WIDTH] =
                                    apply_mode(out_q[chan_idx_s*DATA_WIDTH +: DATA_WIDTH],
                                               bus.dat_i, mask_s, mode_s);
                                2'd2: w1c_s[chan_idx_s*DATA_WIDTH +: DATA_WIDTH] =
                                    bus.dat_i & mask_s;
                                2'd3: en_d[chan_idx_s*DATA_WIDTH +: DATA_WIDTH] =
                                    apply_mode(en_q[chan_idx_s*DATA_WIDTH +: DATA_WIDTH],
                                               bus.dat_i, mask_s, mode_s);
                                default: w1c_s = {NW{1'b0}};
                            endcase
                        end else begin
                            w1c_s = {NW{1'b0}};
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A new rising edge outranks a software clear on the same cycle.
    assign flag_d = (flag_q & ~w1c_s) | rise_s;

    // All state: registers, synchroniser chain, flags and registered outputs.
    always_ff @(posedge bus.clk_i or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= {DATA_WIDTH{1'b0}};
            out_q   <= {CHANNELS{RESET_PAT}};
            en_q    <= {NW{1'b0}};
            flag_q  <= {NW{1'b0}};
            prev_q  <= {NW{1'b0}};
            sync_q  <= {(SYNC_STAGES*NW){1'b0}};
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            out_q   <= out_d;
            en_q    <= en_d;
            flag_q  <= flag_d;
            prev_q  <= sync_q[SYNC_STAGES-1];
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            irq_q   <= |(flag_q & en_q);
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.dat_o = dat_q;
    assign bus.rty_o = 1'b0;
    assign bus.tgd_o = TGD;
    assign gpio_out  = out_q;
    assign irq       = irq_q;
endmodule
